// File: rtl/forwarding_pkg.sv
// Shared types and helpers for the ID-stage forwarding scoreboard.
// The stage field is sized for the largest supported pipeline depth, so one
// struct type serves every parametrisation of the scoreboard.
package forwarding_pkg;

   localparam int STAGE_W_MAX = 8;
   localparam int FWD_REGFILE = 0;

   typedef struct packed {
      logic                   valid;
      logic [STAGE_W_MAX-1:0] stage;
      logic                   is_load;
   } sb_entry_t;

   function automatic int stage_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// Pending-write state for one architectural register.
// Tracks which post-ID stage currently holds the youngest write to this register.
// A flush clears only a stage-1 entry. Younger in-flight writes are squashed, and a
// flush is honoured even while hold is asserted.
module scoreboard_entry
   import forwarding_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic      i_clk,
   input  logic      i_reset,
   input  logic      i_hold,
   input  logic      i_flush,
   input  logic      i_issue,
   input  logic      i_issue_is_load,
   output sb_entry_t o_entry
);

   localparam logic [STAGE_W_MAX-1:0] FIRST = STAGE_W_MAX'(1);
   localparam logic [STAGE_W_MAX-1:0] LAST  = STAGE_W_MAX'(DEPTH);

   sb_entry_t r_entry;

   // Advance, retire, issue or squash this register's pending write.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_entry <= '0;
      end else if (i_flush && r_entry.valid && (r_entry.stage == FIRST)) begin
         r_entry <= '0;
      end else if (!i_hold) begin
         if (i_issue) begin
            r_entry <= '{valid: 1'b1, stage: FIRST, is_load: i_issue_is_load};
         end else if (r_entry.valid) begin
            if (r_entry.stage == LAST) r_entry <= '0;
            else                       r_entry.stage <= r_entry.stage + FIRST;
         end
      end
   end

   assign o_entry = r_entry;

endmodule

// File: rtl/forwarding_scoreboard.sv
// Pending-write scoreboard and forwarding/interlock unit for the ID stage.
// Each read port is given a bypass select: 0 selects the regfile, and k selects
// the result in stage k. A load that is still younger than LDRDY raises stall.
// Optional feature macro: FWD_STALL_STATS_EN (saturating stall-cycle counter).
module forwarding_scoreboard
   import forwarding_pkg::*;
#(
   parameter int NREG  = 8,
   parameter int NREAD = 2,
   parameter int DEPTH = 3,
   parameter int LDRDY = 2
) (
   input  logic                                  i_clk,
   input  logic                                  i_reset,
   input  logic                                  i_hold,
   input  logic                                  i_flush,
   input  logic                                  i_issue_valid,
   input  logic [$clog2(NREG)-1:0]               i_issue_rd,
   input  logic                                  i_issue_is_load,
   input  logic [NREAD*$clog2(NREG)-1:0]         i_rd_addr,
   input  logic [NREAD-1:0]                      i_rd_used,
   output logic [NREAD*stage_w(DEPTH)-1:0]       o_fwd_sel,
   output logic                                  o_stall,
   output logic [31:0]                           o_stall_count
);

   localparam int RW = $clog2(NREG);
   localparam int SW = stage_w(DEPTH);
   localparam logic [STAGE_W_MAX-1:0] LAST  = STAGE_W_MAX'(DEPTH);
   localparam logic [STAGE_W_MAX-1:0] READY = STAGE_W_MAX'(LDRDY);

   sb_entry_t w_entry [NREG];
   logic      w_iss;

   assign w_iss = i_issue_valid & ~o_stall & ~i_hold & ~i_flush;

   for (genvar g = 0; g < NREG; g++) begin : g_entry
      scoreboard_entry #(.DEPTH(DEPTH)) u_entry (
         .i_clk           (i_clk),
         .i_reset         (i_reset),
         .i_hold          (i_hold),
         .i_flush         (i_flush),
         .i_issue         (w_iss && (i_issue_rd == RW'(g))),
         .i_issue_is_load (i_issue_is_load),
         .o_entry         (w_entry[g])
      );
   end

   // Per-port bypass select and load-use interlock from the current scoreboard state.
   // An entry at stage DEPTH is written through the regfile, so it needs no bypass.
   always_comb begin
      o_fwd_sel = {NREAD{SW'(FWD_REGFILE)}};
      o_stall   = 1'b0;
      for (int p = 0; p < NREAD; p++) begin
         if (i_rd_used[p] && w_entry[i_rd_addr[p*RW +: RW]].valid) begin
            if (w_entry[i_rd_addr[p*RW +: RW]].stage != LAST)
               o_fwd_sel[p*SW +: SW] = SW'(w_entry[i_rd_addr[p*RW +: RW]].stage);
            if (w_entry[i_rd_addr[p*RW +: RW]].is_load &&
                (w_entry[i_rd_addr[p*RW +: RW]].stage < READY))
               o_stall = 1'b1;
         end
      end
   end

`ifdef FWD_STALL_STATS_EN
   logic [31:0] r_stall_count;

   // Count stalled cycles that are not frozen by hold, saturating at all-ones.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         r_stall_count <= '0;
      else if (o_stall && !i_hold && (r_stall_count != 32'hFFFF_FFFF))
         r_stall_count <= r_stall_count + 32'd1;
   end

   assign o_stall_count = r_stall_count;
`else
   assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_forwarding_scoreboard.sv
module tb_forwarding_scoreboard;

   localparam int NREG  = 8;
   localparam int NREAD = 2;
   localparam int DEPTH = 3;
   localparam int LDRDY = 2;

   logic        clk;
   logic        rst;
   logic        hold;
   logic        flush;
   logic        issue_valid;
   logic [2:0]  issue_rd;
   logic        issue_is_load;
   logic [5:0]  rd_addr;
   logic [1:0]  rd_used;
   logic [3:0]  fwd_sel;
   logic        stall;
   logic [31:0] stall_count;

   int n_checks = 0;
   int n_errors = 0;

   forwarding_scoreboard #(.NREG(NREG), .NREAD(NREAD), .DEPTH(DEPTH), .LDRDY(LDRDY)) dut (
      .i_clk           (clk),
      .i_reset         (rst),
      .i_hold          (hold),
      .i_flush         (flush),
      .i_issue_valid   (issue_valid),
      .i_issue_rd      (issue_rd),
      .i_issue_is_load (issue_is_load),
      .i_rd_addr       (rd_addr),
      .i_rd_used       (rd_used),
      .o_fwd_sel       (fwd_sel),
      .o_stall         (stall),
      .o_stall_count   (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: list of every accepted writer in program order with its age
   // in stages since issue. A read sees the youngest writer of that register.
   typedef struct {
      int rd;
      bit ld;
      int age;
      bit killed;
   } minst_t;

   minst_t q[$];
   int     m_sel[NREAD];
   bit     m_stall;
   int     m_count;

   function automatic int youngest(input int r);
      for (int k = q.size() - 1; k >= 0; k--)
         if (q[k].rd == r) return k;
      return -1;
   endfunction

   task automatic model_eval();
      m_stall = 0;
      for (int p = 0; p < NREAD; p++) begin
         int a;
         int k;
         m_sel[p] = 0;
         a = int'(rd_addr[p*3 +: 3]);
         k = youngest(a);
         if (rd_used[p] && k >= 0 && !q[k].killed && q[k].age <= DEPTH) begin
            if (q[k].age < DEPTH) m_sel[p] = q[k].age;
            if (q[k].ld && q[k].age < LDRDY) m_stall = 1;
         end
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < q.size(); k++) begin
         if (flush && !q[k].killed && q[k].age == 1) q[k].killed = 1;
         if (!hold && q[k].age <= DEPTH + 1) q[k].age++;
      end
      if (m_stall && !hold) m_count++;
      if (issue_valid && !m_stall && !hold && !flush)
         q.push_back('{rd: int'(issue_rd), ld: issue_is_load, age: 1, killed: 0});
      while (q.size() > 0 && q[0].age > DEPTH) void'(q.pop_front());
   endtask

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input bit h, input bit f, input bit iv, input int rd, input bit ld,
                        input int a0, input int a1, input bit u0, input bit u1);
      hold          = h;
      flush         = f;
      issue_valid   = iv;
      issue_rd      = 3'(rd);
      issue_is_load = ld;
      rd_addr       = {3'(a1), 3'(a0)};
      rd_used       = {u1, u0};
   endtask

   // One cycle: inputs applied after the edge, outputs sampled at negedge, model stepped at posedge.
   task automatic cyc(input bit h, input bit f, input bit iv, input int rd, input bit ld,
                      input int a0, input int a1, input bit u0, input bit u1,
                      output int s0, output int s1, output bit st);
      drive(h, f, iv, rd, ld, a0, a1, u0, u1);
      @(negedge clk);
      s0 = int'(fwd_sel[1:0]);
      s1 = int'(fwd_sel[3:2]);
      st = stall;
      model_eval();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      q.delete();
      m_count = 0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit h, f, iv;
      int rd;
      bit ld;
      int a0, a1;
      bit u0, u1;
      int e0, e1;
      bit es;
   } vec_t;

   vec_t vt[17];

   initial begin
      int s0, s1;
      bit st;

      //            h f iv rd ld a0 a1 u0 u1 e0 e1 es
      vt[0]  = '{0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0};  // issue r3 ALU
      vt[1]  = '{0, 0, 0, 0, 0, 3, 0, 1, 0, 1, 0, 0};  // r3 in EX
      vt[2]  = '{0, 0, 0, 0, 0, 3, 0, 1, 0, 2, 0, 0};
      vt[3]  = '{0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0};  // at WB: regfile
      vt[4]  = '{0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0};  // issue r5 load
      vt[5]  = '{0, 0, 0, 0, 0, 0, 5, 0, 1, 0, 1, 1};  // load-use stall
      vt[6]  = '{0, 0, 0, 0, 0, 5, 5, 0, 1, 0, 2, 0};  // unused port0 -> 0
      vt[7]  = '{0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0};  // r2 ALU
      vt[8]  = '{0, 0, 1, 2, 1, 2, 0, 1, 0, 1, 0, 0};  // r2 load overwrites
      vt[9]  = '{0, 0, 0, 0, 0, 2, 0, 1, 0, 1, 0, 1};  // youngest is load
      vt[10] = '{0, 0, 0, 0, 0, 2, 0, 1, 0, 2, 0, 0};
      vt[11] = '{0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0};  // issue r4
      vt[12] = '{0, 1, 1, 6, 0, 4, 6, 1, 1, 1, 0, 0};  // flush with r6 issue
      vt[13] = '{0, 0, 0, 0, 0, 4, 6, 1, 1, 0, 0, 0};  // both gone
      vt[14] = '{0, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0};  // r7 load
      vt[15] = '{0, 0, 1, 1, 0, 7, 0, 1, 0, 1, 0, 1};  // stall blocks r1 issue
      vt[16] = '{0, 0, 0, 0, 0, 7, 1, 1, 1, 2, 0, 0};

      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      do_reset();

      drive(0, 0, 0, 0, 0, 1, 2, 1, 1);
      @(negedge clk);
      check("reset_sel", longint'(fwd_sel), 0);
      check("reset_stall", longint'(stall), 0);
      check("reset_count", longint'(stall_count), 0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 17; i++) begin
         cyc(vt[i].h, vt[i].f, vt[i].iv, vt[i].rd, vt[i].ld,
             vt[i].a0, vt[i].a1, vt[i].u0, vt[i].u1, s0, s1, st);
         check($sformatf("vec%0d_sel0", i), s0, vt[i].e0);
         check($sformatf("vec%0d_sel1", i), s1, vt[i].e1);
         check($sformatf("vec%0d_stall", i), st, vt[i].es);
      end

      // Hold freezes r1 at stage 1 and blocks issue; release lets it advance.
      do_reset();
      cyc(0, 0, 1, 1, 0, 0, 0, 0, 0, s0, s1, st);
      cyc(1, 0, 1, 6, 0, 1, 0, 1, 0, s0, s1, st);
      check("hold_c1", s0, 1);
      cyc(1, 0, 0, 0, 0, 1, 0, 1, 0, s0, s1, st);
      check("hold_c2", s0, 1);
      cyc(1, 0, 0, 0, 0, 1, 6, 1, 1, s0, s1, st);
      check("hold_c3", s0, 1);
      check("hold_no_issue", s1, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 1, 0, s0, s1, st);
      check("hold_release_now", s0, 1);
      cyc(0, 0, 0, 0, 0, 1, 0, 1, 0, s0, s1, st);
      check("hold_release_adv", s0, 2);

      // Asynchronous reset in the middle of a cycle forgets pending writes.
      cyc(0, 0, 1, 2, 0, 0, 0, 0, 0, s0, s1, st);
      cyc(0, 0, 1, 3, 1, 2, 0, 1, 0, s0, s1, st);
      check("pre_reset_sel", s0, 1);
      drive(0, 0, 0, 0, 0, 2, 3, 1, 1);
      #2;
      check("pre_reset_stall", longint'(stall), 1);
      rst = 1'b1;
      #1;
      check("mid_reset_sel", longint'(fwd_sel), 0);
      check("mid_reset_stall", longint'(stall), 0);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      m_count = 0;
      @(posedge clk);
      #1;

`ifdef FWD_STALL_STATS_EN
      // Three load-use stall cycles, one under hold: two are counted.
      do_reset();
      cyc(0, 0, 1, 5, 1, 0, 0, 0, 0, s0, s1, st);
      cyc(0, 0, 1, 6, 1, 0, 5, 0, 1, s0, s1, st);
      check("stats_stall1", st, 1);
      cyc(0, 0, 1, 6, 1, 0, 0, 0, 0, s0, s1, st);
      cyc(1, 0, 0, 0, 0, 6, 0, 1, 0, s0, s1, st);
      check("stats_stall_hold", st, 1);
      cyc(0, 0, 0, 0, 0, 6, 0, 1, 0, s0, s1, st);
      check("stats_stall3", st, 1);
      check("stats_count", longint'(stall_count), 2);
`endif

      // Randomised traffic against the reference model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         bit h, f, iv, ld, u0, u1;
         h  = ($urandom_range(0, 7) == 0);
         f  = ($urandom_range(0, 9) == 0);
         iv = ($urandom_range(0, 3) != 0);
         ld = ($urandom_range(0, 2) == 0);
         u0 = ($urandom_range(0, 4) != 0);
         u1 = ($urandom_range(0, 4) != 0);
         cyc(h, f, iv, $urandom_range(0, 7), ld, $urandom_range(0, 7), $urandom_range(0, 7),
             u0, u1, s0, s1, st);
         check("rand_sel0", s0, m_sel[0]);
         check("rand_sel1", s1, m_sel[1]);
         check("rand_stall", st, m_stall);
      end
`ifdef FWD_STALL_STATS_EN
      check("rand_count", longint'(stall_count), m_count);
`else
      check("count_tied_zero", longint'(stall_count), 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
